// File: rtl/coherent_dcache_pkg.sv
// Shared types for the L1 data cache: word, MSI state, frame layout and
// the address field widths (tag | index | block offset | byte).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BYTE_W = 2;
  localparam int OFF_W  = 1;
  localparam int IDX_W  = 4;
  localparam int TAG_W  = 32 - IDX_W - OFF_W - BYTE_W;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    M = 2'd2
  } msi_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    word_t [1:0]      data;
    msi_t             msi;
  } dframe_t;

endpackage

// File: rtl/coherent_dcache_frames.sv
// Frame storage for the direct-mapped cache: a CPU read port, a snoop read
// port and a single whole-frame write port. Reads are combinational.
module dcache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] cpu_idx,
  output dframe_t          cpu_frame,
  input  logic [IDX_W-1:0] snp_idx,
  output dframe_t          snp_frame,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  dframe_t          wframe
);

  dframe_t frames [SETS];

  assign cpu_frame = frames[cpu_idx];
  assign snp_frame = frames[snp_idx];

  // All frames come out of reset invalid; one frame is rewritten per cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) frames[i] <= '0;
    end else if (we) begin
      frames[widx] <= wframe;
    end
  end

endmodule

// File: rtl/coherent_dcache.sv
// Per-core L1 data cache with MSI state per frame. Hits complete
// combinationally in IDLE; misses write back a dirty victim and refetch
// the block. Controller snoops take priority over the pipeline, and halt
// flushes every dirty frame before raising the sticky flushed flag.
module coherent_dcache
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 16,  // must equal 2**IDX_W
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  typedef enum logic [3:0] {
    IDLE, WB1, WB2, FETCH1, FETCH2, SNOOP, SWB1, SWB2, FLUSH, FWB1, FWB2, DONE
  } state_t;

  localparam logic             LAST_OFF = 1'(BLKWORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  word_t            fill0;
  logic [31:3]      snp_q;
  logic             inv_q;

  // Request address split
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_off;
  assign req_tag = dmemaddr[31:32-TAG_W];
  assign req_idx = dmemaddr[BYTE_W+OFF_W +: IDX_W];
  assign req_off = dmemaddr[BYTE_W];

  // Snoop address: live during the lookup cycle, latched afterwards
  logic [31:3]      snp_blk;
  logic [TAG_W-1:0] snp_tag;
  logic [IDX_W-1:0] snp_idx;
  assign snp_blk = (state == SNOOP) ? ccsnoopaddr[31:3] : snp_q;
  assign snp_tag = snp_blk[31:32-TAG_W];
  assign snp_idx = snp_blk[3 +: IDX_W];

  logic flush_st;
  assign flush_st = (state == FLUSH) || (state == FWB1) || (state == FWB2);

  logic [IDX_W-1:0] cpu_idx;
  assign cpu_idx = flush_st ? cnt : req_idx;

  dframe_t          cpu_frame, snp_frame, wframe;
  logic             we;
  logic [IDX_W-1:0] widx;

  dcache_frames #(.SETS(SETS)) u_frames (
    .CLK       (CLK),
    .nRST      (nRST),
    .cpu_idx   (cpu_idx),
    .cpu_frame (cpu_frame),
    .snp_idx   (snp_idx),
    .snp_frame (snp_frame),
    .we        (we),
    .widx      (widx),
    .wframe    (wframe)
  );

  // Hit detection; only IDLE without a pending snoop may complete an access
  logic tag_eq, ld_hit, st_hit, can_hit, miss, snp_match;
  assign tag_eq    = (cpu_frame.msi != I) && (cpu_frame.tag == req_tag);
  assign ld_hit    = dmemREN && !dmemWEN && tag_eq;
  assign st_hit    = dmemWEN && tag_eq && (cpu_frame.msi == M);
  assign can_hit   = (state == IDLE) && !ccwait;
  assign miss      = (dmemREN || dmemWEN) && !(ld_hit || st_hit);
  assign snp_match = (snp_frame.msi != I) && (snp_frame.tag == snp_tag);

  assign dhit     = can_hit && (ld_hit || st_hit);
  assign dmemload = (can_hit && ld_hit) ? cpu_frame.data[req_off] : '0;

  logic unused_addr;
  assign unused_addr = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};

  // Frame write port: store hits, fill completion, snoop and flush downgrades
  always_comb begin
    we     = 1'b0;
    widx   = cpu_idx;
    wframe = cpu_frame;
    case (state)
      IDLE: if (can_hit && st_hit) begin
        we = 1'b1;
        wframe.data[req_off] = dmemstore;
      end
      FETCH2: if (!dwait) begin
        we           = 1'b1;
        wframe.tag   = req_tag;
        wframe.data  = {dload, fill0};
        wframe.msi   = dmemWEN ? M : S;
      end
      SNOOP: if (snp_match && snp_frame.msi != M && ccinv) begin
        we         = 1'b1;
        widx       = snp_idx;
        wframe     = snp_frame;
        wframe.msi = I;
      end
      SWB2: if (!dwait) begin
        we         = 1'b1;
        widx       = snp_idx;
        wframe     = snp_frame;
        wframe.msi = inv_q ? I : S;
      end
      FWB2: if (!dwait) begin
        we         = 1'b1;
        wframe.msi = I;
      end
      default: ;
    endcase
  end

  // Control FSM; memory/coherence outputs are registered with the state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      fill0   <= '0;
      snp_q   <= '0;
      inv_q   <= 1'b0;
      flushed <= 1'b0;
      dREN    <= 1'b0;
      dWEN    <= 1'b0;
      daddr   <= '0;
      dstore  <= '0;
      cctrans <= 1'b0;
      ccwrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            state <= SNOOP;
          end else if (halt) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (miss) begin
            if (cpu_frame.msi == M) begin
              state  <= WB1;
              dWEN   <= 1'b1;
              daddr  <= {cpu_frame.tag, req_idx, 1'b0, 2'b00};
              dstore <= cpu_frame.data[0];
            end else begin
              state   <= FETCH1;
              dREN    <= 1'b1;
              cctrans <= 1'b1;
              ccwrite <= dmemWEN;
              daddr   <= {req_tag, req_idx, 1'b0, 2'b00};
            end
          end
        end
        WB1: if (!dwait) begin
          state  <= WB2;
          daddr  <= {cpu_frame.tag, req_idx, LAST_OFF, 2'b00};
          dstore <= cpu_frame.data[1];
        end
        WB2: if (!dwait) begin
          state   <= FETCH1;
          dWEN    <= 1'b0;
          dstore  <= '0;
          dREN    <= 1'b1;
          cctrans <= 1'b1;
          ccwrite <= dmemWEN;
          daddr   <= {req_tag, req_idx, 1'b0, 2'b00};
        end
        FETCH1: if (!dwait) begin
          state <= FETCH2;
          fill0 <= dload;
          daddr <= {req_tag, req_idx, LAST_OFF, 2'b00};
        end
        FETCH2: if (!dwait) begin
          state   <= IDLE;
          dREN    <= 1'b0;
          cctrans <= 1'b0;
          ccwrite <= 1'b0;
          daddr   <= '0;
        end
        SNOOP: begin
          snp_q <= ccsnoopaddr[31:3];
          inv_q <= ccinv;
          if (snp_match && snp_frame.msi == M) begin
            state   <= SWB1;
            dWEN    <= 1'b1;
            ccwrite <= 1'b1;
            daddr   <= {ccsnoopaddr[31:3], 1'b0, 2'b00};
            dstore  <= snp_frame.data[0];
          end else if (!ccwait) begin
            state <= IDLE;
          end
        end
        SWB1: if (!dwait) begin
          state  <= SWB2;
          daddr  <= {snp_q, LAST_OFF, 2'b00};
          dstore <= snp_frame.data[1];
        end
        SWB2: if (!dwait) begin
          state   <= IDLE;
          dWEN    <= 1'b0;
          ccwrite <= 1'b0;
          daddr   <= '0;
          dstore  <= '0;
        end
        FLUSH: begin
          if (cpu_frame.msi == M) begin
            state  <= FWB1;
            dWEN   <= 1'b1;
            daddr  <= {cpu_frame.tag, cnt, 1'b0, 2'b00};
            dstore <= cpu_frame.data[0];
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state   <= DONE;
              flushed <= 1'b1;
            end
          end
        end
        FWB1: if (!dwait) begin
          state  <= FWB2;
          daddr  <= {cpu_frame.tag, cnt, LAST_OFF, 2'b00};
          dstore <= cpu_frame.data[1];
        end
        FWB2: if (!dwait) begin
          dWEN   <= 1'b0;
          daddr  <= '0;
          dstore <= '0;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state   <= DONE;
            flushed <= 1'b1;
          end else begin
            state <= FLUSH;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_dcache.sv
// Randomized bench for coherent_dcache: a flat architectural memory plus
// an MSI frame model predict load data and the exact memory traffic of
// every access, snoop and flush.
module tb_coherent_dcache;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, halt, dwait, ccwait, ccinv;
  logic [31:0] dmemaddr, dmemstore, dload, ccsnoopaddr;
  logic [31:0] dmemload, daddr, dstore;
  logic        dhit, flushed, dREN, dWEN, cctrans, ccwrite;

  coherent_dcache #(.SETS(16), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload),
    .dhit(dhit), .halt(halt), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          wr, ccw, cct;
    int          cyc;
  } xfer_t;

  xfer_t       log_q[$], exp_q[$];
  logic [31:0] mem[512], shadow[512];
  logic [24:0] mtag[16];
  logic [31:0] mdata[16][2];
  int          mmsi[16];           // 0 invalid, 1 shared, 2 modified
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0;

  initial begin CLK = 0; forever #5 CLK = ~CLK; end
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: random stalls, transfers logged when dwait is low
  initial begin
    int stalls;
    xfer_t e;
    stalls = 0; dwait = 1; dload = '0;
    forever begin
      @(negedge CLK);
      if (nRST && (dREN || dWEN)) begin
        if (stalls < 3 && $urandom_range(0, 99) < 40) begin
          dwait = 1; stalls++;
        end else begin
          dwait = 0; stalls = 0;
          e.addr = daddr; e.wr = dWEN; e.ccw = ccwrite; e.cct = cctrans; e.cyc = cyc;
          if (dWEN) begin
            e.data = dstore; mem[daddr[10:2]] = dstore;
          end else begin
            dload = mem[daddr[10:2]]; e.data = dload;
          end
          log_q.push_back(e);
        end
      end else begin
        dwait = 1;
      end
    end
  end

  function automatic logic [31:0] baddr(input logic [24:0] tg, input int idx, input int w);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {tg, i4, 1'(w), 2'b00};
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit ccw, input bit cct);
    xfer_t e;
    e.addr = a; e.data = d; e.wr = wr; e.ccw = ccw; e.cct = cct; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic cmp_traffic(input string tag);
    chk({tag, "_xfer_n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_xfer_addr"}, {log_q[i].wr, log_q[i].ccw, log_q[i].cct, log_q[i].addr},
          {exp_q[i].wr, exp_q[i].ccw, exp_q[i].cct, exp_q[i].addr});
      if (exp_q[i].wr) chk({tag, "_xfer_data"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {dhit, dREN, dWEN, cctrans, ccwrite, flushed}, 6'b0);
    chk({tag, "_daddr"}, daddr, 32'h0);
    chk({tag, "_dstore"}, dstore, 32'h0);
    chk({tag, "_dmemload"}, dmemload, 32'h0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mmsi[i] = 0;
    for (int i = 0; i < 512; i++) shadow[i] = mem[i];
  endtask

  // One pipeline load or store, predicted from the frame model
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int idx, w, lat, hc;
    logic [24:0] tg;
    bit hit, got;
    idx = int'(a[6:3]); w = int'(a[2]); tg = a[31:7];
    exp_q.delete(); log_q.delete();
    hit = mmsi[idx] != 0 && mtag[idx] == tg && (!wr || mmsi[idx] == 2);
    if (!hit) begin
      if (mmsi[idx] == 2) begin
        push_exp(baddr(mtag[idx], idx, 0), mdata[idx][0], 1, 0, 0);
        push_exp(baddr(mtag[idx], idx, 1), mdata[idx][1], 1, 0, 0);
      end
      push_exp(baddr(tg, idx, 0), 0, 0, wr, 1);
      push_exp(baddr(tg, idx, 1), 0, 0, wr, 1);
      mtag[idx] = tg;
      mdata[idx][0] = shadow[{tg[3:0], a[6:3], 1'b0}];
      mdata[idx][1] = shadow[{tg[3:0], a[6:3], 1'b1}];
      mmsi[idx] = wr ? 2 : 1;
    end
    @(negedge CLK);
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = wd;
    got = 0; lat = 0; hc = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      if (dhit) begin
        got = 1; lat = k; hc = cyc;
        if (!wr) chk("ld_data", dmemload, shadow[a[10:2]]);
        break;
      end
    end
    chk("hit_seen", got, 1);
    if (got) begin @(posedge CLK); #1; end
    dmemREN = 0; dmemWEN = 0;
    if (wr) begin
      shadow[a[10:2]] = wd; mdata[idx][w] = wd; mmsi[idx] = 2;
    end
    cmp_traffic(wr ? "st" : "ld");
    if (hit) chk("hit_lat", lat, 0);
    else if (got && log_q.size() > 0) chk("fill_lat", hc - log_q[$].cyc, 1);
  endtask

  // Controller snoop with a load held on the pipeline side the whole time
  task automatic snoop(input logic [31:0] a, input bit inv);
    int idx;
    logic [24:0] tg;
    bit hitm, saw;
    idx = int'(a[6:3]); tg = a[31:7];
    exp_q.delete(); log_q.delete();
    hitm = mmsi[idx] == 2 && mtag[idx] == tg;
    if (hitm) begin
      push_exp(baddr(tg, idx, 0), mdata[idx][0], 1, 1, 0);
      push_exp(baddr(tg, idx, 1), mdata[idx][1], 1, 1, 0);
      mmsi[idx] = inv ? 0 : 1;
    end else if (mmsi[idx] != 0 && mtag[idx] == tg && inv) begin
      mmsi[idx] = 0;
    end
    @(negedge CLK);
    ccwait = 1; ccsnoopaddr = a; ccinv = inv; dmemREN = 1; dmemaddr = a;
    saw = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      saw |= dhit;
      if (hitm ? log_q.size() >= 2 : k >= 2) break;
    end
    ccwait = 0; ccinv = 0; dmemREN = 0;
    repeat (2) @(negedge CLK);
    chk("snp_no_dhit", saw, 0);
    cmp_traffic("snp");
  endtask

  function automatic logic [31:0] raddr();
    return {21'b0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'b00};
  endfunction

  initial begin
    nRST = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0; halt = 0;
    ccwait = 0; ccinv = 0; ccsnoopaddr = 0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[32'h40 >> 2] = 32'hAAAA0001;
    mem[32'h44 >> 2] = 32'hAAAA0002;
    model_clear();
    #12;
    chk_quiet("reset");
    @(negedge CLK); nRST = 1;

    // Directed: cold load, upgrade store, hit, dirty eviction, snoops
    access(0, 32'h40, 0);
    chk("cold_ld_val", shadow[32'h40 >> 2], 32'hAAAA0001);
    access(1, 32'h44, 32'h0000DEAD);
    access(0, 32'h44, 0);
    access(0, 32'hC0, 0);
    access(1, 32'h44, 32'h12345678);
    snoop(32'h44, 1);
    snoop(32'h1C0, 0);
    access(0, 32'h40, 0);
    snoop(32'h40, 0);

    // Random mix of loads, stores and snoops
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 15) snoop(raddr(), 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 1) == 1) access(1, raddr(), $urandom);
      else access(0, raddr(), 0);
    end
    access(1, 32'h10, 32'h22220002);
    access(1, 32'h48, 32'h99990009);

    // Flush: every modified frame written back in index order
    exp_q.delete(); log_q.delete();
    for (int i = 0; i < 16; i++)
      if (mmsi[i] == 2) begin
        push_exp(baddr(mtag[i], i, 0), mdata[i][0], 1, 0, 0);
        push_exp(baddr(mtag[i], i, 1), mdata[i][1], 1, 0, 0);
        mmsi[i] = 0;
      end
    @(negedge CLK); halt = 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK); #1;
      if (flushed) break;
    end
    chk("flushed", flushed, 1);
    cmp_traffic("flush");

    // DONE ignores snoops
    log_q.delete();
    ccwait = 1; ccsnoopaddr = 32'h10; ccinv = 1;
    repeat (4) @(negedge CLK);
    #1;
    chk("done_snp_traffic", log_q.size(), 0);
    chk("done_sticky", {flushed, dWEN, ccwrite}, 3'b100);
    ccwait = 0; ccinv = 0;

    // Reset mid-flush
    @(negedge CLK); nRST = 0; halt = 0;
    #1 chk_quiet("reset2");
    @(negedge CLK); nRST = 1;
    model_clear();
    access(1, 32'h10, 32'h0BAD0002);
    access(1, 32'h48, 32'h0BAD0009);
    @(negedge CLK); halt = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK); #1;
      if (dWEN) break;
    end
    chk("midflush_wen", dWEN, 1);
    nRST = 0; halt = 0;
    #1 chk_quiet("reset_mid");
    @(negedge CLK); @(negedge CLK);
    #1 chk_quiet("reset_hold");
    nRST = 1;
    model_clear();
    access(0, 32'h10, 0);
    access(0, 32'h48, 0);
    for (int n = 0; n < 20; n++) access(1'($urandom_range(0, 1)), raddr(), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
